// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures RxData on each rising edge of the UART
// frame-complete flag and drains it through a registered read port.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              reset_n,
  input  logic [7:0]        RxData,
  input  logic              flag,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              flag_d_reg;
  logic              overflow_reg, overflow_next;
  logic [7:0]        rd_data_reg;
  logic              rd_valid_reg;

  logic wr_req;
  logic wr_accept;
  logic rd_accept;
  logic empty_int;
  logic full_int;

  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == (ADDR_W+1)'(DEPTH));

  // A full FIFO still takes the write when a read frees a slot in the same cycle.
  assign wr_req    = flag & ~flag_d_reg;
  assign rd_accept = rd_en & ~empty_int;
  assign wr_accept = wr_req & (~full_int | rd_accept);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (ovf_clr) overflow_next = 1'b0;
    // A drop in the same cycle as a clear must not be lost.
    if (wr_req && !wr_accept) overflow_next = 1'b1;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      flag_d_reg   <= 1'b1;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      flag_d_reg   <= flag;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge Clock) begin
    if (wr_accept) mem[wr_ptr_reg] <= RxData;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign empty    = empty_int;
  assign full     = full_int;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It detects the receiver's end-of-frame `flag` and captures the 8-bit `RxData` word present at that moment into a synchronous circular FIFO. The consumer logic (CPU bus, display, command parser) then drains it through a registered read port. It reports occupancy, full and empty, and keeps a sticky overflow indication so bytes arriving faster than they are drained are never silently lost.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, minimum 2.
- `ADDR_W`, default 4: log2(`DEPTH`); pointer width.
- `Clock`  in  1: system clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `RxData`  in  8: received byte from the UART receiver; stable while `flag` is high.
- `flag`  in  1: receiver frame-complete level; high for one or more cycles per frame.
- `rd_en`  in  1: read request from the consumer.
- `ovf_clr`  in  1: clears `overflow`.
- `rd_data`  out  8: registered read data.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` holds a newly read byte.
- `empty`  out  1: no entries stored.
- `full`  out  1: `DEPTH` entries stored.
- `count`  out  `ADDR_W`+1: number of stored entries, 0..`DEPTH`.
- `overflow`  out  1: sticky; at least one byte was dropped.

## Operation
- **Frame capture:**
  - A write request (`wr_req`) is raised by the rising edge of `flag` only: `flag` high and registered `flag_d` low.
  - `flag_d` resets to 1, so a `flag` already high when reset releases is not captured.
  - A `flag` held high for many cycles produces exactly one write.
- **Write acceptance:**
  - `wr_req` is accepted when `!full`.
  - It is also accepted when `full` and a read is accepted in the same cycle; the write lands in the slot being freed.
  - On acceptance: `mem[wr_ptr] <= RxData`, and `wr_ptr` increments modulo `DEPTH` (natural wrap).
  - When `wr_req` is not accepted, the byte is dropped, `overflow` is set, and the pointers and `count` are unchanged.
- **Read acceptance:**
  - `rd_en` is accepted when `!empty`, with `empty` evaluated before the edge.
  - A write into an empty FIFO in the same cycle does not make that read acceptable.
  - On acceptance: `rd_data <= mem[rd_ptr]`, `rd_ptr` increments modulo `DEPTH`, and `rd_valid <= 1`.
  - In any cycle without an accepted read, `rd_valid <= 0` and `rd_data` holds its last value.
  - `rd_en` while empty is ignored and does not touch `overflow`.
- **Occupancy:**
  - `count` is +1 on a write-only cycle, -1 on a read-only cycle, and unchanged when both or neither are accepted.
  - `empty = (count == 0)` and `full = (count == DEPTH)`; both are decoded from the `count` register.
- **Overflow:**
  - Set by a dropped write; cleared by `ovf_clr`.
  - If a drop and `ovf_clr` occur in the same cycle, set wins.
- **Reset values (asynchronous):**
  - `wr_ptr = rd_ptr = 0`, `count = 0`, `empty = 1`, `full = 0`.
  - `rd_data = 8'h00`, `rd_valid = 0`, `overflow = 0`, `flag_d = 1`.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes immediately.

## Timing
- **Write latency:** `flag` rises before edge N → byte written at edge N. `count`, `empty` and `full` reflect it after edge N, and the byte is readable with `rd_en` sampled at edge N+1.
- **Read latency:** `rd_en` sampled high at edge M with `!empty` → `rd_data` and `rd_valid` are valid after edge M, for one cycle. `count` updates at the same edge.
- **Back-to-back reads:** `rd_en` held high drains one byte per cycle until `empty`. The read that empties the FIFO is accepted; the next one is ignored.
- **Throughput margin:** frames arrive at most once per ~10 bit periods, so reads always outpace writes when `rd_en` is serviced.
- **Critical path:** `count` compare → accept logic; no combinational path from inputs to outputs.

## Test plan
- **Reset state:** assert `reset_n`=0 mid-clock → outputs reach reset values without waiting for an edge. Release, hold `flag`=1 → `count` stays 0.
- **Single byte:** pulse `flag` for 5 cycles with `RxData`=8'hA5 → `count`=1 exactly once. `rd_en` for one cycle → next cycle `rd_data`=8'hA5, `rd_valid`=1, `empty`=1.
- **Fill and wrap:** write 8'h00..8'h0F (16 frames) → `full`=1, `count`=16. Read 8 bytes, write 8'h10..8'h17, read 16 → bytes come out in order 8'h08..8'h17.
- **Overflow:**
  - With `full`=1, pulse `flag` with 8'hEE → `overflow`=1, `count`=16, and 8'hEE is never read.
  - `ovf_clr`=1 in the same cycle as a second drop → `overflow` stays 1.
  - Later `ovf_clr` alone → `overflow`=0.
- **Simultaneous access:**
  - `full` plus `flag` edge plus `rd_en` in one cycle → both accepted, `count` stays 16, no overflow.
  - `empty` plus `flag` edge plus `rd_en` in one cycle → write only, `rd_valid`=0, `count`=1.
- **Empty read:** `rd_en` held high for 3 cycles while empty → `rd_valid` stays 0, `rd_data` unchanged, `count` stays 0.
